// File: rtl/encoder_sampler_pkg.sv
// rtl/encoder_sampler_pkg.sv - shared widths, count-mode encodings and decode helpers
package encoder_sampler_pkg;

    localparam int COUNT_W = 14;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 14'd16383;

    // COUNT_MODE encodings
    localparam int COUNT_MODE_X1 = 0;  // rising edges of filtered A only
    localparam int COUNT_MODE_X4 = 1;  // every single-line Gray transition

    // Result of decoding one previous/current filtered {A,B} pair
    typedef struct packed {
        logic inc;        // one pulse to count
        logic dir_valid;  // dir field is meaningful this cycle
        logic dir;        // 1 = A leads B
        logic err;        // both lines changed at once
    } decode_t;

    // Decode one transition; pairs are {A,B}
    function automatic decode_t decode_pair(input logic [1:0] prev,
                                            input logic [1:0] cur,
                                            input int         mode);
        decode_t    d;
        logic [1:0] chg;
        d   = '0;
        chg = prev ^ cur;
        if (chg == 2'b11) begin
            d.err = 1'b1;
        end else if (mode == COUNT_MODE_X4) begin
            if (chg != 2'b00) begin
                d.inc       = 1'b1;
                d.dir_valid = 1'b1;
                // Forward sequence 00->10->11->01->00
                d.dir = chg[1] ? (cur[1] ^ cur[0]) : ~(cur[1] ^ cur[0]);
            end
        end else if (chg == 2'b10 && cur[1]) begin
            d.inc       = 1'b1;
            d.dir_valid = 1'b1;
            d.dir       = ~cur[0];
        end
        return d;
    endfunction

    // Saturating add of a small increment to the pulse count
    function automatic logic [COUNT_W-1:0] sat_add(input logic [COUNT_W-1:0] cnt,
                                                   input logic [1:0]         add);
        logic [COUNT_W:0] sum;
        sum = {1'b0, cnt} + {{(COUNT_W-1){1'b0}}, add};
        return (sum > {1'b0, COUNT_MAX}) ? COUNT_MAX : sum[COUNT_W-1:0];
    endfunction

endpackage

// File: rtl/encoder_sampler_if.sv
// rtl/encoder_sampler_if.sv - encoder inputs and PID-facing outputs of the sampler
interface encoder_sampler_if;
    import encoder_sampler_pkg::*;

    logic               enc_a;
    logic               enc_b;
    logic               reset_nop;
    logic [COUNT_W-1:0] number_of_pulses;
    logic               PID_timer;
    logic               o_dir;
    logic               o_enc_err;

    modport master (
        output enc_a, enc_b, reset_nop,
        input  number_of_pulses, PID_timer, o_dir, o_enc_err
    );

    modport slave (
        input  enc_a, enc_b, reset_nop,
        output number_of_pulses, PID_timer, o_dir, o_enc_err
    );

endinterface

// File: rtl/encoder_sampler_enc_filter.sv
// rtl/encoder_sampler_enc_filter.sv - 2-flop synchronizer plus run-length glitch filter for one line
module enc_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic i_Clk,
    input  logic reset,
    input  logic line_i,
    output logic line_o   // filtered value that the line holds after the coming edge
);

    logic       sync1_q, sync2_q;
    logic       filt_q, filt_d;
    logic [3:0] run_q, run_d;

    // Two-stage synchronizer for the asynchronous encoder line
    always_ff @(posedge i_Clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive differing samples; flip on the FILTER_LEN-th one
    always_comb begin
        run_d  = '0;
        filt_d = filt_q;
        if (sync2_q != filt_q) begin
            if (run_q == 4'(FILTER_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                run_d = run_q + 4'd1;
            end
        end
    end

    // Filter state register
    always_ff @(posedge i_Clk) begin
        if (reset) begin
            filt_q <= 1'b0;
            run_q  <= '0;
        end else begin
            filt_q <= filt_d;
            run_q  <= run_d;
        end
    end

    // Exposing the next value lets the decoder count on the same edge the line flips
    assign line_o = filt_d;

endmodule

// File: rtl/encoder_sampler.sv
// rtl/encoder_sampler.sv - quadrature decode, saturating pulse count and PID sample-window timer
module encoder_sampler
    import encoder_sampler_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 5_000_000,
    parameter int FILTER_LEN    = 4,
    parameter int COUNT_MODE    = COUNT_MODE_X1
) (
    input  logic              i_Clk,
    input  logic              reset,
    encoder_sampler_if.slave  bus
);

    localparam int              TMR_W    = 24;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);

    logic               a_filt, b_filt;
    logic [1:0]         prev_q, prev_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               pend_q, pend_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               pid_q, pid_d;
    logic               dir_q, dir_d;
    logic               err_q, err_d;
    decode_t            dec;

    enc_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .i_Clk  (i_Clk),
        .reset  (reset),
        .line_i (bus.enc_a),
        .line_o (a_filt)
    );

    enc_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .i_Clk  (i_Clk),
        .reset  (reset),
        .line_i (bus.enc_b),
        .line_o (b_filt)
    );

    // Decode, count, direction, error and window timer next-state
    always_comb begin
        prev_d  = {a_filt, b_filt};
        dec     = decode_pair(prev_q, {a_filt, b_filt}, COUNT_MODE);
        count_d = count_q;
        pend_d  = 1'b0;
        dir_d   = dec.dir_valid ? dec.dir : dir_q;
        err_d   = err_q | dec.err;
        pid_d   = (tmr_q == TMR_LAST);
        tmr_d   = (tmr_q == TMR_LAST) ? '0 : tmr_q + 1'b1;

        if (bus.reset_nop) begin
            // Clear wins over any edge decoded this cycle
            count_d = '0;
        end else if (pid_q) begin
            // Hold the count steady while the consumer captures it
            pend_d = dec.inc | pend_q;
        end else begin
            count_d = sat_add(count_q, {1'b0, dec.inc} + {1'b0, pend_q});
        end
    end

    // State registers; reset overrides every count and timer event
    always_ff @(posedge i_Clk) begin
        if (reset) begin
            prev_q  <= 2'b00;
            count_q <= '0;
            pend_q  <= 1'b0;
            tmr_q   <= '0;
            pid_q   <= 1'b0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            tmr_q   <= tmr_d;
            pid_q   <= pid_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    assign bus.number_of_pulses = count_q;
    assign bus.PID_timer        = pid_q;
    assign bus.o_dir            = dir_q;
    assign bus.o_enc_err        = err_q;

endmodule

// File: tb/tb_encoder_sampler.sv
// tb/tb_encoder_sampler.sv - self-checking bench for encoder_sampler
module tb_encoder_sampler;
    import encoder_sampler_pkg::*;

    logic i_Clk     = 1'b0;
    logic reset     = 1'b1;
    logic enc_a     = 1'b0;
    logic enc_b     = 1'b0;
    logic reset_nop = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 i_Clk = ~i_Clk;

    encoder_sampler_if if0 ();
    encoder_sampler_if if1 ();
    encoder_sampler_if if2 ();

    assign if0.enc_a = enc_a;  assign if0.enc_b = enc_b;  assign if0.reset_nop = reset_nop;
    assign if1.enc_a = enc_a;  assign if1.enc_b = enc_b;  assign if1.reset_nop = reset_nop;
    assign if2.enc_a = enc_a;  assign if2.enc_b = enc_b;  assign if2.reset_nop = reset_nop;

    encoder_sampler #(.SAMPLE_PERIOD(100), .FILTER_LEN(4), .COUNT_MODE(0)) u0 (
        .i_Clk(i_Clk), .reset(reset), .bus(if0.slave));
    encoder_sampler #(.SAMPLE_PERIOD(100), .FILTER_LEN(4), .COUNT_MODE(1)) u1 (
        .i_Clk(i_Clk), .reset(reset), .bus(if1.slave));
    encoder_sampler #(.SAMPLE_PERIOD(65536), .FILTER_LEN(4), .COUNT_MODE(1)) u2 (
        .i_Clk(i_Clk), .reset(reset), .bus(if2.slave));

    // Cycles since the last clock edge that sampled reset high
    always @(posedge i_Clk) cyc <= reset ? 0 : cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        int cyc;
        int cnt;
    } sb_t;
    sb_t sbq[$];
    sb_t sb_e;

    // Scoreboard: each PID strobe pops the expected cycle and captured count
    always @(negedge i_Clk) begin
        if (!reset && if0.PID_timer && sbq.size() > 0) begin
            sb_e = sbq.pop_front();
            check("pid_cycle", cyc, sb_e.cyc);
            check("pid_count", int'(if0.number_of_pulses), sb_e.cnt);
        end
    end

    typedef struct {
        int pulses;
        int hi;
        int lo;
        int exp0;
        int exp1;
    } vec_t;
    vec_t vecs[5];

    task automatic ticks(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    task automatic wait_sb(input int budget);
        int n = 0;
        while (sbq.size() > 0 && n < budget) begin
            @(negedge i_Clk);
            n++;
        end
        if (sbq.size() > 0) begin
            check("sb_timeout", sbq.size(), 0);
            sbq.delete();
        end
    endtask

    task automatic wait_mod(input int m);
        int n = 0;
        do begin
            @(negedge i_Clk);
            n++;
        end while ((cyc % 100) != m && n < 200);
    endtask

    task automatic clear_nop();
        reset_nop = 1'b1;
        ticks(1);
        reset_nop = 1'b0;
    endtask

    task automatic pulse_a(input int hi, input int lo);
        enc_a = 1'b1;
        ticks(hi);
        enc_a = 1'b0;
        ticks(lo);
    endtask

    task automatic quad(input logic [1:0] s0, input logic [1:0] s1,
                        input logic [1:0] s2, input logic [1:0] s3);
        logic [1:0] seq [4];
        seq[0] = s0; seq[1] = s1; seq[2] = s2; seq[3] = s3;
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < 4; k++) begin
                {enc_a, enc_b} = seq[k];
                ticks(10);
            end
        end
    endtask

    initial begin
        vecs[0] = '{7, 10, 10, 7, 14};
        vecs[1] = '{1,  3, 10, 0,  0};
        vecs[2] = '{1,  4, 10, 1,  2};
        vecs[3] = '{3,  5,  6, 3,  6};
        vecs[4] = '{2,  2, 10, 0,  0};

        // Reset state
        repeat (3) @(posedge i_Clk);
        @(negedge i_Clk);
        check("rst_count0", int'(if0.number_of_pulses), 0);
        check("rst_pid0",   int'(if0.PID_timer), 0);
        check("rst_dir0",   int'(if0.o_dir), 0);
        check("rst_err0",   int'(if0.o_enc_err), 0);
        check("rst_count1", int'(if1.number_of_pulses), 0);
        check("rst_err1",   int'(if1.o_enc_err), 0);

        // Idle windows
        sbq.push_back('{100, 0});
        sbq.push_back('{200, 0});
        sbq.push_back('{300, 0});
        reset = 1'b0;
        wait_sb(400);
        check("idle_count", int'(if0.number_of_pulses), 0);

        // Table-driven pulse trains on A
        for (int v = 0; v < 5; v++) begin
            clear_nop();
            ticks(3);
            for (int p = 0; p < vecs[v].pulses; p++) pulse_a(vecs[v].hi, vecs[v].lo);
            ticks(15);
            check($sformatf("vec%0d_x1", v), int'(if0.number_of_pulses), vecs[v].exp0);
            check($sformatf("vec%0d_x4", v), int'(if1.number_of_pulses), vecs[v].exp1);
        end

        // Input edge to count latency
        clear_nop();
        wait_mod(10);
        enc_a = 1'b1;
        ticks(5);
        check("lat_before", int'(if0.number_of_pulses), 0);
        ticks(1);
        check("lat_at6_x1", int'(if0.number_of_pulses), 1);
        check("lat_at6_x4", int'(if1.number_of_pulses), 1);
        ticks(10);
        enc_a = 1'b0;
        ticks(10);

        // Edge decoded in the PID cycle is deferred one cycle
        wait_mod(95);
        enc_a = 1'b1;
        ticks(5);
        check("defer_pid",   int'(if0.PID_timer), 1);
        check("defer_cnt0",  int'(if0.number_of_pulses), 1);
        ticks(1);
        check("defer_cnt1",  int'(if0.number_of_pulses), 1);
        ticks(1);
        check("defer_cnt2",  int'(if0.number_of_pulses), 2);
        enc_a = 1'b0;
        ticks(12);

        // Consumer-style window: capture at PID, clear, four pulses, capture again
        wait_mod(0);
        reset_nop = 1'b1;
        ticks(1);
        reset_nop = 1'b0;
        sbq.push_back('{cyc + 99, 4});
        for (int p = 0; p < 4; p++) pulse_a(10, 10);
        wait_sb(120);

        // Quadrature, A leading then B leading
        clear_nop();
        ticks(3);
        quad(2'b10, 2'b11, 2'b01, 2'b00);
        ticks(15);
        check("fwd_x4_cnt", int'(if1.number_of_pulses), 20);
        check("fwd_x4_dir", int'(if1.o_dir), 1);
        check("fwd_x1_cnt", int'(if0.number_of_pulses), 5);
        check("fwd_x1_dir", int'(if0.o_dir), 1);
        clear_nop();
        ticks(3);
        quad(2'b01, 2'b11, 2'b10, 2'b00);
        ticks(15);
        check("rev_x4_cnt", int'(if1.number_of_pulses), 20);
        check("rev_x4_dir", int'(if1.o_dir), 0);
        check("rev_x1_cnt", int'(if0.number_of_pulses), 5);
        check("rev_x1_dir", int'(if0.o_dir), 0);

        // Edge decoded while reset_nop is held is dropped
        wait_mod(20);
        enc_a = 1'b1;
        ticks(2);
        reset_nop = 1'b1;
        ticks(6);
        reset_nop = 1'b0;
        ticks(2);
        check("nop_x1", int'(if0.number_of_pulses), 0);
        check("nop_x4", int'(if1.number_of_pulses), 0);
        enc_a = 1'b0;
        ticks(10);
        check("nop_x1_fall", int'(if0.number_of_pulses), 0);

        // Saturation: 20000 x4 transitions, one every two cycles
        clear_nop();
        ticks(3);
        for (int i = 0; i < 20000; i++) begin
            if ((i % 2) == 0) enc_a = ~enc_a;
            else              enc_b = ~enc_b;
            ticks(2);
        end
        ticks(15);
        check("sat_u2",     int'(if2.number_of_pulses), 16383);
        check("sat_u1",     int'(if1.number_of_pulses), 16383);
        check("sat_u0",     int'(if0.number_of_pulses), 5000);
        check("sat_u2_dir", int'(if2.o_dir), 1);

        // Both lines change together
        enc_a = 1'b1;
        enc_b = 1'b1;
        ticks(12);
        check("err_u0",     int'(if0.o_enc_err), 1);
        check("err_u1",     int'(if1.o_enc_err), 1);
        check("err_u0_cnt", int'(if0.number_of_pulses), 5000);
        check("err_u1_cnt", int'(if1.number_of_pulses), 16383);
        check("err_u0_dir", int'(if0.o_dir), 1);
        check("err_u1_dir", int'(if1.o_dir), 1);

        // Reset in mid-window restarts the timer
        wait_mod(50);
        reset = 1'b1;
        enc_a = 1'b0;
        enc_b = 1'b0;
        ticks(2);
        check("mid_rst_cnt", int'(if0.number_of_pulses), 0);
        check("mid_rst_pid", int'(if0.PID_timer), 0);
        check("mid_rst_dir", int'(if0.o_dir), 0);
        check("mid_rst_err", int'(if0.o_enc_err), 0);
        check("mid_rst_err1", int'(if1.o_enc_err), 0);
        sbq.push_back('{100, 0});
        reset = 1'b0;
        wait_sb(150);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder_sampler.md
ENCODER_SAMPLER -- requirements
Module: encoder_sampler

Interface
REQ-001 Parameter SAMPLE_PERIOD, default 5_000_000: clock cycles per PID sample window (100 ms at 50 MHz); legal range 16..2^24-1.
REQ-002 Parameter FILTER_LEN, default 4: consecutive equal synchronized samples required before a filtered encoder line changes; legal range 2..15.
REQ-003 Parameter COUNT_MODE, default 0: 0 = count rising edges of filtered A only; 1 = count every valid quadrature transition (x4).
REQ-004 i_Clk  input  1  system clock.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of i_Clk.
REQ-006 enc_a  input  1  encoder channel A, asynchronous to i_Clk.
REQ-007 enc_b  input  1  encoder channel B, asynchronous to i_Clk.
REQ-008 reset_nop  input  1  count-clear request from the PID controller; level-sensitive.
REQ-009 number_of_pulses  output  14  unsigned live pulse count of the current window, registered.
REQ-010 PID_timer  output  1  one-cycle strobe marking the end of a sample window, registered.
REQ-011 o_dir  output  1  last decoded rotation direction: 1 = A leads B, 0 = B leads A.
REQ-012 o_enc_err  output  1  sticky flag: an illegal quadrature transition (A and B both changed in one filtered update) was seen.

Function
REQ-013 Each encoder line SHALL pass a 2-flop synchronizer and then a glitch filter; the filtered value changes only after FILTER_LEN consecutive synchronized samples differ from it.
REQ-014 Latency from a clean input edge to the filtered edge SHALL be exactly 2 + FILTER_LEN cycles.
REQ-015 The block SHALL keep the previous filtered pair {A,B} and decode one transition per cycle from the previous and current pairs.
REQ-016 COUNT_MODE 0: count +1 on each filtered-A 0->1 transition, regardless of B.
REQ-017 COUNT_MODE 1: count +1 on each single-line Gray-code transition in either direction; counts are magnitude only, unsigned.
REQ-018 o_dir SHALL update on every valid transition; in COUNT_MODE 0 it samples filtered B at the A rising edge (B=0 -> 1, B=1 -> 0).
REQ-019 A both-lines-changed transition SHALL NOT change the count or o_dir, and SHALL set o_enc_err until reset.
REQ-020 The count SHALL saturate at 16383 and never wrap.
REQ-021 While reset_nop is 1 the count SHALL be forced to 0; an edge decoded in a cycle with reset_nop=1 is discarded (clear wins).
REQ-022 Window timer: counter runs 0..SAMPLE_PERIOD-1 and wraps to 0; PID_timer is 1 for exactly the one cycle after the counter holds SAMPLE_PERIOD-1, giving a period of exactly SAMPLE_PERIOD cycles.
REQ-023 The timer SHALL free-run and SHALL NOT be affected by reset_nop, count saturation or o_enc_err.
REQ-024 number_of_pulses SHALL be stable (no increment) in the cycle PID_timer is 1; an edge decoded in that cycle is applied in the following cycle, so the consumer's capture at PID_timer sees a consistent value.
REQ-025 Downstream contract: the PID controller captures number_of_pulses on the cycle it sees PID_timer=1 and then holds reset_nop=1 for its computation cycles; pulses in that interval are intentionally dropped.

Reset
REQ-026 On reset: synchronizer and filter states = 0, previous pair = 00, count = 0, timer = 0, PID_timer = 0, o_dir = 0, o_enc_err = 0.
REQ-027 Reset asserted mid-window SHALL restart the timer so the first PID_timer after deassertion occurs SAMPLE_PERIOD cycles later.
REQ-028 Reset SHALL take priority over reset_nop and over every count or timer event in the same cycle.

Structure
REQ-029 Shared package SHALL hold COUNT_W = 14, COUNT_MAX = 14'd16383 and the COUNT_MODE encodings.
REQ-030 One sub-module enc_filter (synchronizer plus FILTER_LEN glitch filter, one line) SHALL be instantiated twice, for A and B; decode, count and timer stay in encoder_sampler.

Verification (bench: SAMPLE_PERIOD=100, FILTER_LEN=4)
REQ-031 Reset released, no encoder activity -> PID_timer pulses at cycles 100, 200, 300 after release; number_of_pulses stays 0.
REQ-032 COUNT_MODE 0, 7 clean A periods (A high 10 cycles, low 10 cycles) inside one window, reset_nop=0 -> number_of_pulses = 7 at PID_timer; each increment occurs 6 cycles after the A rising edge.
REQ-033 A glitch of 3 cycles, then one of 4 cycles -> the first is ignored; the second produces exactly one count.
REQ-034 COUNT_MODE 1, 5 full quadrature cycles, A leading B -> count 20, o_dir=1; reversed order -> o_dir=0, count 20 again after a reset_nop clear.
REQ-035 Hold reset_nop=1 for 6 cycles while an A edge is decoded -> count 0 when reset_nop falls; then drive 20000 edges with SAMPLE_PERIOD raised -> count holds at 16383.
REQ-036 Toggle A and B in the same cycle -> o_enc_err=1, count and o_dir unchanged; assert reset at timer=50 -> all outputs 0 and next PID_timer 100 cycles after deassertion.
